// File: rtl/salva_bebe_multi_if.sv
// Sensor/actuator bundle for the multi-seat child-left-in-vehicle monitor.
// Front-end inputs (en, puerta, presencia, temp) and fan/buzzer/display outputs.
interface salva_bebe_multi_if #(
  parameter int N_SEAT = 2,
  parameter int TW     = 5
);
  logic                   en;
  logic                   puerta;
  logic [N_SEAT-1:0]      presencia;
  logic [N_SEAT*TW-1:0]   temp;
  logic                   vent;
  logic                   aaviso;
  logic                   alarma;
  logic [3:0]             anodos;
  logic [6:0]             seg;

  modport master (
    output en, puerta, presencia, temp,
    input  vent, aaviso, alarma, anodos, seg
  );

  modport slave (
    input  en, puerta, presencia, temp,
    output vent, aaviso, alarma, anodos, seg
  );
endinterface

// File: rtl/salva_bebe_multi.sv
// Multi-seat vehicle occupant heat monitor: vent -> warn -> latched alarm escalation
// plus 4-digit 7-seg readout of hottest occupied seat. Optional: SALVA_ALARM_BLINK_EN.
module salva_bebe_multi_seat #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pres_i,
  input  logic [TW-1:0] temp_i,
  output logic          pres_q_o,
  output logic [TW-1:0] temp_q_o
);
  logic          pres_q;
  logic [TW-1:0] temp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pres_q <= 1'b0;
      temp_q <= '0;
    end else begin
      pres_q <= pres_i;
      temp_q <= temp_i;
    end
  end

  assign pres_q_o = pres_q;
  assign temp_q_o = temp_q;
endmodule

module salva_bebe_multi #(
  parameter int N_SEAT      = 2,
  parameter int TW          = 5,
  parameter int T_VENT      = 25,
  parameter int T_ALARM     = 30,
  parameter int HYST        = 2,
  parameter int TICK_DIV    = 50000,
  parameter int VENT_TICKS  = 1000,
  parameter int WARN_TICKS  = 500,
  parameter int BLINK_TICKS = 250
) (
  input  logic               clk,
  input  logic               reset,
  salva_bebe_multi_if.slave  bus
);
  localparam int PW   = $clog2(TICK_DIV);
  localparam int TMAX = (VENT_TICKS > WARN_TICKS) ? VENT_TICKS : WARN_TICKS;
  localparam int TMW  = $clog2(TMAX + 1);
  localparam logic [7:0] VENT_TH  = 8'(T_VENT);
  localparam logic [7:0] OFF_TH   = 8'(T_VENT - HYST);
  localparam logic [7:0] ALARM_TH = 8'(T_ALARM);

  typedef enum logic [2:0] {S_IDLE, S_MON, S_VENT, S_WARN, S_ALARM} state_e;

  logic                         en_q, puerta_q;
  logic [N_SEAT-1:0]            pres_q;
  logic [N_SEAT-1:0][TW-1:0]    temp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q     <= 1'b0;
      puerta_q <= 1'b0;
    end else begin
      en_q     <= bus.en;
      puerta_q <= bus.puerta;
    end
  end

  for (genvar g = 0; g < N_SEAT; g++) begin : g_seat
    salva_bebe_multi_seat #(.TW(TW)) u_seat (
      .clk      (clk),
      .reset    (reset),
      .pres_i   (bus.presencia[g]),
      .temp_i   (bus.temp[g*TW +: TW]),
      .pres_q_o (pres_q[g]),
      .temp_q_o (temp_q[g])
    );
  end

  // Hottest occupied seat; strict '>' keeps the lowest index on ties.
  logic [TW-1:0] tmax;
  logic [3:0]    hot;
  logic [7:0]    tmax8;
  logic          risk;

  always_comb begin
    tmax = '0;
    hot  = '0;
    for (int i = 0; i < N_SEAT; i++) begin
      if (pres_q[i] && (hot == 4'd0 || temp_q[i] > tmax)) begin
        tmax = temp_q[i];
        hot  = 4'(i + 1);
      end
    end
  end

  assign tmax8 = 8'(tmax);
  assign risk  = (|pres_q) & ~puerta_q;

  logic [PW-1:0]  presc_q, presc_d;
  logic           tick;
  logic [TMW-1:0] timer_q, timer_d;
  state_e         state_q, state_d;
  logic           vent_done, warn_done;

  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d   = tick ? '0 : presc_q + 1'b1;
  assign vent_done = tick && (timer_q >= TMW'(VENT_TICKS - 1));
  assign warn_done = tick && (timer_q >= TMW'(WARN_TICKS - 1));

  always_comb begin
    state_d = state_q;
    if (!en_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_MON;
        S_MON:   if (risk && tmax8 >= VENT_TH) state_d = S_VENT;
        S_VENT: begin
          if (!risk)                                 state_d = S_MON;
          else if (tmax8 >= ALARM_TH || vent_done)   state_d = S_WARN;
          else if (tmax8 < OFF_TH)                   state_d = S_MON;
        end
        S_WARN: begin
          if (puerta_q)       state_d = S_MON;
          else if (warn_done) state_d = S_ALARM;
        end
        S_ALARM: if (puerta_q) state_d = S_MON;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) timer_d = '0;
    else if (tick)          timer_d = timer_q + 1'b1;
  end

  logic alarm_on;
`ifdef SALVA_ALARM_BLINK_EN
  localparam int BW = $clog2(BLINK_TICKS + 1);
  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  always_comb begin
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (state_d == S_ALARM && state_q != S_ALARM) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (state_q == S_ALARM && tick) begin
      if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign alarm_on = blink_d;
`else
  assign alarm_on = 1'b1;
`endif

  // Display: digit value is picked with the next pointer so anode and segments switch together.
  logic [1:0] dig_q, dig_d;
  logic [3:0] d_hund, d_tens, d_unit, d_val;
  logic [7:0] rem;
  logic [3:0] anodos_d;
  logic [6:0] seg_d;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'h3F;  4'd1: seg7 = 7'h06;  4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;  4'd4: seg7 = 7'h66;  4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;  4'd7: seg7 = 7'h07;  4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign dig_d = tick ? dig_q + 2'd1 : dig_q;

  always_comb begin
    d_hund   = (tmax8 >= 8'd100) ? 4'd1 : 4'd0;
    rem      = (tmax8 >= 8'd100) ? tmax8 - 8'd100 : tmax8;
    d_tens   = 4'(rem / 8'd10);
    d_unit   = 4'(rem % 8'd10);
    case (dig_d)
      2'd3:    d_val = hot;
      2'd2:    d_val = d_hund;
      2'd1:    d_val = d_tens;
      default: d_val = d_unit;
    endcase
    anodos_d = ~(4'b0001 << dig_d);
    seg_d    = ~seg7(d_val);
    if (state_d == S_IDLE) begin
      anodos_d = 4'hF;
      seg_d    = 7'h7F;
    end
  end

  logic       vent_q, aaviso_q, alarma_q;
  logic [3:0] anodos_q;
  logic [6:0] seg_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      timer_q  <= '0;
      dig_q    <= '0;
      vent_q   <= 1'b0;
      aaviso_q <= 1'b0;
      alarma_q <= 1'b0;
      anodos_q <= 4'hF;
      seg_q    <= 7'h7F;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      timer_q  <= timer_d;
      dig_q    <= dig_d;
      vent_q   <= state_d inside {S_VENT, S_WARN, S_ALARM};
      aaviso_q <= state_d inside {S_WARN, S_ALARM};
      alarma_q <= (state_d == S_ALARM) && alarm_on;
      anodos_q <= anodos_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.vent   = vent_q;
  assign bus.aaviso = aaviso_q;
  assign bus.alarma = alarma_q;
  assign bus.anodos = anodos_q;
  assign bus.seg    = seg_q;
endmodule

// File: tb/tb_salva_bebe_multi.sv
// Scoreboard bench for salva_bebe_multi: escalation timing, hysteresis, door/enable
// overrides, async reset and the multiplexed display.
module tb_salva_bebe_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;
  logic hold;
  logic [6:0] seg_tab [10];

  always #5 clk = ~clk;

  salva_bebe_multi_if #(.N_SEAT(2), .TW(5)) bus ();

  salva_bebe_multi #(
    .N_SEAT(2), .TW(5), .T_VENT(25), .T_ALARM(30), .HYST(2),
    .TICK_DIV(4), .VENT_TICKS(8), .WARN_TICKS(4), .BLINK_TICKS(2)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct { string tag; logic [2:0] o; } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push_o(input string tag, input logic [2:0] o);
    exp_t e;
    e.tag = tag;
    e.o   = o;
    sb.push_back(e);
  endtask

  task automatic pop_o();
    exp_t e;
    e = sb.pop_front();
    chk(e.tag, {29'd0, bus.vent, bus.aaviso, bus.alarma}, {29'd0, e.o});
  endtask

  task automatic seats(input logic [1:0] p, input logic [4:0] t0, input logic [4:0] t1);
    bus.presencia = p;
    bus.temp      = {t1, t0};
  endtask

  function automatic logic outsel(input int sel);
    case (sel)
      0:       return bus.vent;
      1:       return bus.aaviso;
      default: return bus.alarma;
    endcase
  endfunction

  task automatic wait_out(input int sel, input logic val, input int lim, output int cnt);
    cnt = 0;
    while (outsel(sel) !== val && cnt < lim) begin
      step(1);
      cnt++;
    end
  endtask

  task automatic chk_dig(input string tag, input logic [3:0] an, input int val);
    int k = 0;
    while (bus.anodos !== an && k < 20) begin
      step(1);
      k++;
    end
    chk({tag, "_an"}, {28'd0, bus.anodos}, {28'd0, an});
    chk({tag, "_seg"}, {25'd0, bus.seg}, {25'd0, seg_tab[val]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;

    bus.en = 1'b1; bus.puerta = 1'b0;
    seats(2'b11, 5'd31, 5'd31);
    step(3);
    chk("rst_out", {29'd0, bus.vent, bus.aaviso, bus.alarma}, 32'd0);
    chk("rst_an", {28'd0, bus.anodos}, 32'hF);
    chk("rst_seg", {25'd0, bus.seg}, 32'h7F);

    bus.en = 1'b0;
    seats(2'b01, 5'd31, 5'd0);
    rst_n = 1'b1;
    step(10);
    chk("idle_out", {29'd0, bus.vent, bus.aaviso, bus.alarma}, 32'd0);
    chk("idle_an", {28'd0, bus.anodos}, 32'hF);

    bus.en = 1'b1;
    seats(2'b00, 5'd0, 5'd0);
    step(4);
    chk("mon_onehot", $countones(~bus.anodos), 1);

    // Seat 1 at 27: vent two edges later, then timed escalation.
    seats(2'b10, 5'd0, 5'd27);
    push_o("vent_e1", 3'b000);
    push_o("vent_e2", 3'b100);
    step(1); pop_o();
    step(1); pop_o();
    wait_out(1, 1'b1, 40, n);
    chk("vent2warn_win", (n >= 29 && n <= 32), 1);
    wait_out(2, 1'b1, 40, n);
    chk("warn2alarm", n, 16);
    chk("alarm_all", {29'd0, bus.vent, bus.aaviso, bus.alarma}, 32'd7);

`ifdef SALVA_ALARM_BLINK_EN
    wait_out(2, 1'b0, 20, n);
    chk("blink_hi", n, 8);
    wait_out(2, 1'b1, 20, n);
    chk("blink_lo", n, 8);
    chk("blink_warn", {31'd0, bus.aaviso}, 1);
`endif

    seats(2'b10, 5'd0, 5'd0);
    hold = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      hold &= bus.aaviso & bus.vent;
`ifndef SALVA_ALARM_BLINK_EN
      hold &= bus.alarma;
`endif
    end
    chk("alarm_cold_hold", {31'd0, hold}, 1);

    wait_out(2, 1'b1, 20, n);
    chk("alarm_sync", (n < 20), 1);
    bus.puerta = 1'b1;
    push_o("door_e1", 3'b111);
    push_o("door_e2", 3'b000);
    step(1); pop_o();
    step(1); pop_o();
    bus.puerta = 1'b0;
    step(3);

    // Direct escalation from VENT when a seat reaches the alarm threshold.
    seats(2'b10, 5'd0, 5'd27);
    push_o("dir_vent", 3'b100);
    step(2); pop_o();
    seats(2'b11, 5'd31, 5'd27);
    push_o("dir_e1", 3'b100);
    push_o("dir_e2", 3'b110);
    step(1); pop_o();
    step(1); pop_o();
    chk_dig("d31_3", 4'b0111, 1);
    chk_dig("d31_2", 4'b1011, 0);
    chk_dig("d31_1", 4'b1101, 3);
    chk_dig("d31_0", 4'b1110, 1);

    bus.puerta = 1'b1;
    step(3);
    chk("door_mon", {29'd0, bus.vent, bus.aaviso, bus.alarma}, 32'd0);
    bus.puerta = 1'b0;
    seats(2'b10, 5'd0, 5'd25);
    push_o("hys_in", 3'b100);
    step(2); pop_o();
    seats(2'b10, 5'd0, 5'd23);
    push_o("hys_23", 3'b100);
    step(4); pop_o();
    seats(2'b10, 5'd0, 5'd22);
    push_o("hys_22_e1", 3'b100);
    push_o("hys_22_e2", 3'b000);
    step(1); pop_o();
    step(1); pop_o();

    seats(2'b11, 5'd28, 5'd28);
    push_o("tie_vent", 3'b100);
    step(2); pop_o();
    chk_dig("tie_3", 4'b0111, 1);
    chk_dig("tie_1", 4'b1101, 2);
    chk_dig("tie_0", 4'b1110, 8);
    seats(2'b11, 5'd28, 5'd29);
    step(2);
    chk_dig("hot2_3", 4'b0111, 2);

    bus.en = 1'b0;
    push_o("en_off", 3'b000);
    step(2); pop_o();
    chk("en_off_an", {28'd0, bus.anodos}, 32'hF);

    // Async reset while escalated.
    bus.en = 1'b1;
    seats(2'b10, 5'd0, 5'd27);
    step(6);
    chk("pre_rst_vent", {31'd0, bus.vent}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", {29'd0, bus.vent, bus.aaviso, bus.alarma}, 32'd0);
    chk("async_rst_an", {28'd0, bus.anodos}, 32'hF);
    chk("async_rst_seg", {25'd0, bus.seg}, 32'h7F);
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
